// File: rtl/peri_cmd_master.sv
// peri_cmd_master: host-side initiator for the peripheral address/data port.
// Accepts WRITE / READ / POLL commands, sequences the bus cycles with the
// peripheral's read latency and idle gaps, and returns one response per
// command. All outputs are registered; the next output values are derived
// from the next FSM state so that each state's bus pattern appears in the
// cycle the FSM occupies that state.
module peri_cmd_master #(
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned GAP       = 1,
    parameter int unsigned POLL_MAX  = 1024,
    parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    input  logic [31:0] cmd_mask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [31:0] address_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i
);

    localparam int unsigned ATT_W = $clog2(POLL_MAX + 1);
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;

    // RD lasts READ_LAT+1 cycles: counter runs 0..READ_LAT.
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(READ_LAT);
    // GAPW lasts GAP cycles: counter runs 0..GAP-1 (unused when GAP is 0).
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP == 32'd0) ? {CNT_W{1'b0}} : CNT_W'(GAP - 32'd1);
    localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(POLL_MAX);
    localparam logic [ATT_W-1:0] ATT_ONE  = ATT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_GAPW = 3'd2,
        S_RD   = 3'd3,
        S_CMP  = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    // Masked equality used to decide whether a poll attempt has succeeded.
    function automatic logic poll_match(input logic [31:0] got,
                                        input logic [31:0] expected,
                                        input logic [31:0] mask);
        poll_match = ((got & mask) == (expected & mask));
    endfunction

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [ATT_W-1:0]   att_q,       att_d;
    logic [1:0]         op_q,        op_d;
    logic [31:0]        cmd_addr_q,  cmd_addr_d;
    logic [31:0]        cmd_data_q,  cmd_data_d;
    logic [31:0]        cmd_mask_q,  cmd_mask_d;
    logic [31:0]        rdata_q,     rdata_d;
    logic [31:0]        rsp_data_q,  rsp_data_d;
    logic               rsp_err_q,   rsp_err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q,      busy_d;
    logic               ready_q,     ready_d;
    logic [31:0]        address_q,   address_d;
    logic [31:0]        wdata_q,     wdata_d;

    // Next-state logic plus next values of every registered output.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        att_d      = att_q;
        op_d       = op_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        cmd_mask_d = cmd_mask_q;
        rdata_d    = rdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    op_d       = cmd_op_i;
                    cmd_addr_d = cmd_addr_i;
                    cmd_data_d = cmd_data_i;
                    cmd_mask_d = cmd_mask_i;
                    cnt_d      = {CNT_W{1'b0}};
                    att_d      = ATT_ONE;
                    case (cmd_op_i)
                        OP_WRITE: state_d = S_WR;
                        OP_READ:  state_d = S_RD;
                        OP_POLL:  state_d = S_RD;
                        default: begin
                            // Reserved op: error response, no bus activity.
                            state_d    = S_RSP;
                            rsp_data_d = 32'h0000_0000;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WR: begin
                cnt_d = {CNT_W{1'b0}};
                if (GAP == 32'd0) begin
                    state_d    = S_RSP;
                    rsp_data_d = 32'h0000_0000;
                    rsp_err_d  = 1'b0;
                end else begin
                    state_d = S_GAPW;
                end
            end

            S_GAPW: begin
                if (cnt_q >= GAP_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (op_q == OP_WRITE) begin
                        state_d    = S_RSP;
                        rsp_data_d = 32'h0000_0000;
                        rsp_err_d  = 1'b0;
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RD: begin
                if (cnt_q >= RD_LAST) begin
                    // Last address cycle: peripheral data is valid now.
                    rdata_d = data_i;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_CMP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_CMP: begin
                if (op_q == OP_READ) begin
                    state_d    = S_RSP;
                    rsp_data_d = rdata_q;
                    rsp_err_d  = 1'b0;
                end else if (poll_match(rdata_q, cmd_data_q, cmd_mask_q)) begin
                    state_d    = S_RSP;
                    rsp_data_d = rdata_q;
                    rsp_err_d  = 1'b0;
                end else if (att_q >= ATT_MAX) begin
                    state_d    = S_RSP;
                    rsp_data_d = rdata_q;
                    rsp_err_d  = 1'b1;
                end else begin
                    att_d = att_q + ATT_ONE;
                    cnt_d = {CNT_W{1'b0}};
                    if (GAP == 32'd0) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_GAPW;
                    end
                end
            end

            S_RSP: begin
                if (rsp_ready_i) begin
                    state_d    = S_IDLE;
                    rsp_data_d = 32'h0000_0000;
                    rsp_err_d  = 1'b0;
                end else begin
                    state_d = S_RSP;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output values for the state being entered.
        if ((state_d == S_WR) || (state_d == S_RD)) begin
            address_d = cmd_addr_d;
        end else begin
            address_d = IDLE_ADDR;
        end
        if (state_d == S_WR) begin
            wdata_d = cmd_data_d;
        end else begin
            wdata_d = 32'h0000_0000;
        end
        rsp_valid_d = (state_d == S_RSP);
        busy_d      = (state_d != S_IDLE);
        // Ready only in IDLE, which also guarantees no response is pending.
        ready_d     = (state_d == S_IDLE);
    end

    // State, counters, command copies and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            att_q       <= {ATT_W{1'b0}};
            op_q        <= 2'b00;
            cmd_addr_q  <= 32'h0000_0000;
            cmd_data_q  <= 32'h0000_0000;
            cmd_mask_q  <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            rsp_data_q  <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            address_q   <= IDLE_ADDR;
            wdata_q     <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            att_q       <= att_d;
            op_q        <= op_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_mask_q  <= cmd_mask_d;
            rdata_q     <= rdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign address_o   = address_q;
    assign data_o      = wdata_q;

endmodule

// File: tb/tb_peri_cmd_master.sv
// Self-checking bench for peri_cmd_master. A phase-level model turns each
// command into the expected per-cycle bus/handshake trace; one checker
// process compares the DUT against that trace on every falling edge.
module tb_peri_cmd_master;

    localparam int unsigned RL = 2;
    localparam int unsigned GP = 1;
    localparam int unsigned PM = 4;
    localparam logic [31:0] IA = 32'h0000_0000;

    localparam logic [1:0] OP_W = 2'b00;
    localparam logic [1:0] OP_R = 2'b01;
    localparam logic [1:0] OP_P = 2'b10;
    localparam logic [1:0] OP_X = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_data = 32'h0;
    logic [31:0] cmd_mask = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [31:0] address;
    logic [31:0] dout;
    logic [31:0] din = 32'h0;

    peri_cmd_master #(
        .READ_LAT (RL),
        .GAP      (GP),
        .POLL_MAX (PM),
        .IDLE_ADDR(IA)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_op_i   (cmd_op),
        .cmd_addr_i (cmd_addr),
        .cmd_data_i (cmd_data),
        .cmd_mask_i (cmd_mask),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o (rsp_data),
        .rsp_err_o  (rsp_err),
        .busy_o     (busy),
        .address_o  (address),
        .data_o     (dout),
        .data_i     (din)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dout;
        logic [31:0] din;
        logic [31:0] rsp_d;
        logic [31:0] pin_a;
        logic [31:0] pin_e;
        logic        busy;
        logic        rsp_v;
        logic        rsp_e;
        logic        ready;
        logic        pin_v;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        tr_q[$];
    exp_t        rsp_ent;
    exp_t        cur;
    logic [31:0] rd_vals [0:7];
    int          checks = 0;
    int          errors = 0;

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] d,
                                input logic b, input logic rdy, input logic [31:0] di);
        exp_t e;
        e       = '0;
        e.addr  = a;
        e.dout  = d;
        e.busy  = b;
        e.ready = rdy;
        e.din   = di;
        return e;
    endfunction

    function automatic exp_t mk_rsp(input logic [31:0] v, input logic er);
        exp_t e;
        e       = mk(IA, 32'h0, 1'b1, 1'b0, 32'hEEEE_0000);
        e.rsp_v = 1'b1;
        e.rsp_d = v;
        e.rsp_e = er;
        return e;
    endfunction

    // Phase-level model: bus phases and their lengths, response decided from
    // the per-attempt read values.
    task automatic build(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] mask);
        int          att;
        bit          done;
        logic [31:0] v;
        tr_q.delete();
        if (op == OP_W) begin
            tr_q.push_back(mk(addr, data, 1'b1, 1'b0, 32'hAAAA_0001));
            for (int g = 0; g < int'(GP); g++) tr_q.push_back(mk(IA, 32'h0, 1'b1, 1'b0, 32'hAAAA_0002));
            rsp_ent = mk_rsp(32'h0, 1'b0);
        end else if (op == OP_X) begin
            rsp_ent = mk_rsp(32'h0, 1'b1);
        end else begin
            att  = 1;
            done = 1'b0;
            while (!done) begin
                v = rd_vals[att-1];
                for (int i = 0; i <= int'(RL); i++)
                    tr_q.push_back(mk(addr, 32'h0, 1'b1, 1'b0,
                                      (i == int'(RL)) ? v : (32'hBAD0_0000 + 32'(i))));
                tr_q.push_back(mk(IA, 32'h0, 1'b1, 1'b0, 32'hBAD1_0000));
                if (op == OP_R || ((v & mask) == (data & mask))) begin
                    rsp_ent = mk_rsp(v, 1'b0);
                    done    = 1'b1;
                end else if (att == int'(PM)) begin
                    rsp_ent = mk_rsp(v, 1'b1);
                    done    = 1'b1;
                end else begin
                    for (int g = 0; g < int'(GP); g++) tr_q.push_back(mk(IA, 32'h0, 1'b1, 1'b0, 32'hBAD2_0000));
                    att++;
                end
            end
        end
    endtask

    // Drive one command; exp_len is the hand-computed number of cycles
    // between accept and the response (accept edge N, rsp at N+exp_len+1).
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] mask,
                           input int hold, input bit keep_valid,
                           input int abort_at, input int exp_len);
        exp_t e;
        build(op, addr, data, mask);
        @(posedge clk); #2;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_mask  = mask;
        din       = 32'h5555_0000;
        e = mk(IA, 32'h0, 1'b0, 1'b1, 32'h5555_0000);
        if (exp_len >= 0) begin
            e.pin_v = 1'b1;
            e.pin_a = 32'(tr_q.size());
            e.pin_e = 32'(exp_len);
        end
        exp_q.push_back(e);
        for (int i = 0; i < tr_q.size(); i++) begin
            @(posedge clk); #2;
            cmd_valid = keep_valid;
            cmd_op    = ~op;
            cmd_addr  = 32'hFFFF_0000 + 32'(i);
            cmd_data  = 32'hDDDD_0000 + 32'(i);
            cmd_mask  = 32'h0;
            if (i == abort_at) begin
                rst       = 1'b1;
                cmd_valid = 1'b0;
                exp_q.push_back(mk(IA, 32'h0, 1'b0, 1'b0, 32'h0));
                @(posedge clk); #2;
                rst = 1'b0;
                exp_q.push_back(mk(IA, 32'h0, 1'b0, 1'b0, 32'h0));
                return;
            end
            din = tr_q[i].din;
            exp_q.push_back(tr_q[i]);
        end
        for (int h = 0; h <= hold; h++) begin
            @(posedge clk); #2;
            cmd_valid = keep_valid;
            cmd_op    = OP_W;
            cmd_addr  = 32'hC0DE_0000;
            din       = 32'h7777_0000 + 32'(h);
            rsp_ready = (h == hold);
            exp_q.push_back(rsp_ent);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Single compare process: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            if (cur.pin_v) chk("model_latency", cur.pin_a, cur.pin_e);
            chk("address_o",   address,          cur.addr);
            chk("data_o",      dout,             cur.dout);
            chk("busy_o",      {31'h0, busy},      {31'h0, cur.busy});
            chk("cmd_ready_o", {31'h0, cmd_ready}, {31'h0, cur.ready});
            chk("rsp_valid_o", {31'h0, rsp_valid}, {31'h0, cur.rsp_v});
            if (cur.rsp_v) begin
                chk("rsp_data_o", rsp_data,        cur.rsp_d);
                chk("rsp_err_o",  {31'h0, rsp_err}, {31'h0, cur.rsp_e});
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) rd_vals[i] = 32'h0;
        // Reset: outputs at reset values while asserted and one cycle after.
        repeat (2) @(posedge clk);
        #2;
        exp_q.push_back(mk(IA, 32'h0, 1'b0, 1'b0, 32'h0));
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.push_back(mk(IA, 32'h0, 1'b0, 1'b0, 32'h0));

        // WRITE: bus at N+1, idle at N+2, response at N+3.
        run_cmd(OP_W, 32'h10, 32'hA5, 32'h0, 0, 1'b0, -1, 2);
        // READ: address for 3 cycles, response at N+5.
        rd_vals[0] = 32'h1234_5678;
        run_cmd(OP_R, 32'h20, 32'h0, 32'h0, 1, 1'b0, -1, 4);
        // POLL matching on the 4th attempt (= POLL_MAX boundary, match wins).
        rd_vals[0] = 32'h0000_0010; rd_vals[1] = 32'h0;
        rd_vals[2] = 32'h0000_0100; rd_vals[3] = 32'h0000_0001;
        run_cmd(OP_P, 32'h30, 32'h1, 32'h1, 0, 1'b0, -1, 19);
        // POLL never matching: 4 reads, error, last word returned.
        rd_vals[0] = 32'h11; rd_vals[1] = 32'h22; rd_vals[2] = 32'h33; rd_vals[3] = 32'h44;
        run_cmd(OP_P, 32'h40, 32'h5A, 32'hFF, 3, 1'b0, -1, 19);
        // Response held 5 cycles with cmd_valid high; next command back-to-back.
        run_cmd(OP_W, 32'h50, 32'h77, 32'h0, 5, 1'b1, -1, 2);
        rd_vals[0] = 32'hCAFE_F00D;
        run_cmd(OP_R, 32'h60, 32'h0, 32'h0, 0, 1'b0, -1, 4);
        // Reset during RD of a POLL, then normal operation.
        rd_vals[0] = 32'h0;
        run_cmd(OP_P, 32'h70, 32'h1, 32'h1, 0, 1'b0, 2, -1);
        run_cmd(OP_W, 32'h80, 32'h3C, 32'h0, 0, 1'b0, -1, 2);
        // Reserved op: immediate error response, no bus activity.
        run_cmd(OP_X, 32'h90, 32'h99, 32'h0, 1, 1'b0, -1, 0);

        @(posedge clk); #2;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        exp_q.push_back(mk(IA, 32'h0, 1'b0, 1'b1, 32'h0));
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles unchecked", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
